// File: rtl/clint_pkg.sv
// Shared constants for the core-local interruptor: register offsets,
// the mtimecmp reset value and the bus FSM state encoding.
package clint_pkg;

  localparam logic [15:0] MsipAddr     = 16'h0000;
  localparam logic [15:0] MtimecmpAddr = 16'h4000;
  localparam logic [15:0] MtimeAddr    = 16'hBFF8;
  localparam logic [15:0] SsipAddr     = 16'hC000;

  // All ones keeps the timer interrupt quiet until software programs a compare value.
  localparam logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    Idle = 1'b0,
    Ack  = 1'b1
  } bus_state_t;

endpackage

// File: rtl/clint_timer.sv
// Prescaled free-running 64-bit mtime counter with a byte-lane write port.
// A write with any lane enabled takes priority over that cycle's increment.
module clint_timer #(
  parameter int CLOCK_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  wr_sel,
  input  logic [63:0] wr_data,
  output logic [63:0] mtime
);

  localparam int PW = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLOCK_CYCLES - 1);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PrescMax);

  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Unwritten lanes keep their pre-increment bytes when a write collides with a tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      mtime <= '0;
    end else if (|wr_sel) begin
      for (int k = 0; k < 8; k++) begin
        if (wr_sel[k]) begin
          mtime[8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: single-hart bus slave with a registered one-cycle
// acknowledge, holding msip, ssip, mtimecmp and the prescaled mtime counter.
module clint
  import clint_pkg::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int CLOCK_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cyc_i,
  input  logic                   stb_i,
  input  logic                   wr_en_i,
  input  logic [15:0]            addr_i,
  input  logic [DATA_SIZE/8-1:0] sel_i,
  input  logic [DATA_SIZE-1:0]   dat_i,
  output logic [DATA_SIZE-1:0]   dat_o,
  output logic                   ack_o,
  output logic                   msip,
  output logic                   ssip,
  output logic [63:0]            mtime,
  output logic [63:0]            mtimecmp
);

  bus_state_t           state, state_next;
  logic                 req, accept, do_wr, do_rd;
  logic                 hi_word, addr_unused;
  logic                 hit_msip, hit_ssip, hit_cmp, hit_time;
  logic [63:0]          wide_data, rd_wide;
  logic [7:0]           wide_sel, time_sel;
  logic [DATA_SIZE-1:0] rd_data;

  // Bus data is widened to the 64-bit register view; on a 32-bit bus addr_i[2] picks the word.
  if (DATA_SIZE == 64) begin : g_bus64
    assign hi_word     = 1'b0;
    assign wide_data   = dat_i;
    assign wide_sel    = sel_i;
    assign rd_data     = rd_wide;
    assign addr_unused = ^addr_i[2:0];
  end else begin : g_bus32
    assign hi_word     = addr_i[2];
    assign wide_data   = hi_word ? {dat_i, 32'h0} : {32'h0, dat_i};
    assign wide_sel    = hi_word ? {sel_i, 4'h0} : {4'h0, sel_i};
    assign rd_data     = hi_word ? rd_wide[63:32] : rd_wide[31:0];
    assign addr_unused = ^addr_i[1:0];
  end

  assign req      = cyc_i & stb_i;
  assign hit_msip = (addr_i[15:3] == MsipAddr[15:3]) & ~hi_word;
  assign hit_ssip = (addr_i[15:3] == SsipAddr[15:3]) & ~hi_word;
  assign hit_cmp  = (addr_i[15:3] == MtimecmpAddr[15:3]);
  assign hit_time = (addr_i[15:3] == MtimeAddr[15:3]);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= Idle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      Idle: begin
        if (req) begin
          state_next = Ack;
          accept     = 1'b1;
        end
      end
      Ack:     state_next = Idle;
      default: state_next = Idle;
    endcase
  end

  assign ack_o = (state == Ack);
  assign do_wr = accept & wr_en_i;
  assign do_rd = accept & ~wr_en_i;

  always_comb begin
    rd_wide = '0;
    if (hit_msip) begin
      rd_wide[0] = msip;
    end else if (hit_ssip) begin
      rd_wide[0] = ssip;
    end else if (hit_cmp) begin
      rd_wide = mtimecmp;
    end else if (hit_time) begin
      rd_wide = mtime;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      msip     <= 1'b0;
      ssip     <= 1'b0;
      mtimecmp <= MtimecmpReset;
      dat_o    <= '0;
    end else begin
      if (do_wr && hit_msip && wide_sel[0]) begin
        msip <= wide_data[0];
      end
      if (do_wr && hit_ssip && wide_sel[0]) begin
        ssip <= wide_data[0];
      end
      if (do_wr && hit_cmp) begin
        for (int k = 0; k < 8; k++) begin
          if (wide_sel[k]) begin
            mtimecmp[8*k +: 8] <= wide_data[8*k +: 8];
          end
        end
      end
      if (do_rd) begin
        dat_o <= rd_data;
      end
    end
  end

  assign time_sel = (do_wr && hit_time) ? wide_sel : 8'h00;

  clint_timer #(
    .CLOCK_CYCLES(CLOCK_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .wr_sel (time_sel),
    .wr_data(wide_data),
    .mtime  (mtime)
  );

endmodule
